// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add unsigned multiplier, one multiplier bit per clock.
// Uses the divider's start/busy/done handshake so multiply and reduce can be chained.
module shift_add_multiplier #(
    parameter int WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH:0]     acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;
    logic               last_step;

    // Conditional add of the multiplicand; the extra top bit keeps the carry.
    function automatic logic [WIDTH:0] add_partial(
        input logic [WIDTH:0]   acc_in,
        input logic [WIDTH-1:0] m,
        input logic             sel
    );
        return sel ? (acc_in + {1'b0, m}) : acc_in;
    endfunction

    assign sum       = add_partial(acc, mcand, mplr[0]);
    assign shifted   = {sum, mplr} >> 1;
    assign last_step = (cnt == CNT_W'(1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // P is loaded on the final shift so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A;
                        mplr  <= B;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    {acc, mplr} <= shifted;
                    cnt         <= cnt - CNT_W'(1);
                    if (last_step) P <= shifted[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
